can_tx_queue: RTL



---
 rtl/can_pkg.sv | 19 +
 rtl/can_frame_fifo.sv | 59 +++++
 rtl/can_tx_queue.sv | 136 +++++++++++++
 3 files changed

// File: rtl/can_pkg.sv
// Shared types for the CAN transmit queue: frame payload and scheduler states.
package can_pkg;

  localparam int unsigned CAN_ID_W   = 11;
  localparam int unsigned CAN_DATA_W = 64;

  typedef struct packed {
    logic [CAN_ID_W-1:0]   id;
    logic [CAN_DATA_W-1:0] data;
  } can_frame_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    BACKOFF
  } tx_state_e;

endpackage

// File: rtl/can_frame_fifo.sv
// Synchronous frame FIFO; head is visible combinationally, flags and count are registered.
module can_frame_fifo
  import can_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  can_frame_t                 din_i,
  output can_frame_t                 head_c,
  output logic                       empty_o,
  output logic                       not_full_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  can_frame_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;
  logic [CNT_W-1:0] count_nxt;

  // Qualify requests against the registered flags and form the next occupancy.
  always_comb begin
    push_ok   = push_i && not_full_o;
    pop_ok    = pop_i && !empty_o;
    count_nxt = count_o + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  assign head_c = mem[rd_ptr];

  // Pointers, occupancy and flags; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_o    <= '0;
      empty_o    <= 1'b1;
      not_full_o <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count_o    <= count_nxt;
      empty_o    <= (count_nxt == '0);
      not_full_o <= (count_nxt != CNT_W'(DEPTH));
    end
  end

  // Frame storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= din_i;
  end

endmodule

// File: rtl/can_tx_queue.sv
// Transmit frame queue and retry scheduler feeding can_simple_top.
module can_tx_queue
  import can_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned RETRY_GAP = 1000,
  parameter int unsigned TIMEOUT   = 2_000_000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [CAN_ID_W-1:0]   wr_id_i,
  input  logic [CAN_DATA_W-1:0] wr_data_i,
  output logic [CAN_ID_W-1:0]   tx_id_o,
  output logic [CAN_DATA_W-1:0] tx_data_o,
  output logic                  tx_start_strobe_o,
  input  logic                  tx_succeed_i,
  input  logic                  tx_failed_i,
  output logic                  busy_o,
  output logic [15:0]           sent_cnt_o,
  output logic [15:0]           drop_cnt_o,
  output logic                  drop_o
);

  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned GAP_W = $clog2(RETRY_GAP + 1);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  tx_state_e        state;
  logic [TMR_W-1:0] timer;
  logic [RTY_W-1:0] retry_cnt;
  logic [GAP_W-1:0] gap_cnt;

  can_frame_t       fifo_din;
  can_frame_t       fifo_head;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  logic             push_c;
  logic             pop_c;
  logic             fail_evt_c;
  logic             give_up_c;
  logic             idle_nxt_c;
  logic [CNT_W-1:0] count_nxt_c;
  logic             busy_nxt_c;

  // Attempt outcome decode and next-cycle occupancy for the registered busy flag.
  always_comb begin
    fifo_din.id   = wr_id_i;
    fifo_din.data = wr_data_i;
    push_c        = wr_valid_i && wr_ready_o;
    fail_evt_c    = !tx_succeed_i && (tx_failed_i || (timer == TMR_W'(TIMEOUT - 1)));
    give_up_c     = fail_evt_c && (retry_cnt == RTY_W'(MAX_RETRY));
    pop_c         = (state == WAIT) && (tx_succeed_i || give_up_c);
    idle_nxt_c    = ((state == IDLE) && fifo_empty) || pop_c;
    count_nxt_c   = fifo_count + CNT_W'(push_c) - CNT_W'(pop_c);
    busy_nxt_c    = !idle_nxt_c || (count_nxt_c != '0);
  end

  can_frame_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (push_c),
    .pop_i      (pop_c),
    .din_i      (fifo_din),
    .head_c     (fifo_head),
    .empty_o    (fifo_empty),
    .not_full_o (wr_ready_o),
    .count_o    (fifo_count)
  );

  // Scheduler: latch head, strobe, await outcome, back off and retry or drop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state             <= IDLE;
      timer             <= '0;
      retry_cnt         <= '0;
      gap_cnt           <= '0;
      tx_id_o           <= '0;
      tx_data_o         <= '0;
      tx_start_strobe_o <= 1'b0;
      drop_o            <= 1'b0;
      busy_o            <= 1'b0;
      sent_cnt_o        <= '0;
      drop_cnt_o        <= '0;
    end else begin
      tx_start_strobe_o <= 1'b0;
      drop_o            <= 1'b0;
      busy_o            <= busy_nxt_c;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            tx_id_o   <= fifo_head.id;
            tx_data_o <= fifo_head.data;
            retry_cnt <= '0;
            state     <= START;
          end
        end
        START: begin
          tx_start_strobe_o <= 1'b1;
          timer             <= '0;
          state             <= WAIT;
        end
        WAIT: begin
          if (tx_succeed_i) begin
            sent_cnt_o <= sent_cnt_o + 16'd1;
            state      <= IDLE;
          end else if (fail_evt_c) begin
            if (give_up_c) begin
              drop_cnt_o <= drop_cnt_o + 16'd1;
              drop_o     <= 1'b1;
              state      <= IDLE;
            end else begin
              retry_cnt <= retry_cnt + RTY_W'(1);
              gap_cnt   <= '0;
              state     <= BACKOFF;
            end
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        BACKOFF: begin
          if (gap_cnt == GAP_W'(RETRY_GAP - 1)) state <= START;
          else                                  gap_cnt <= gap_cnt + GAP_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
